uart_tx_arbiter: RTL

//  Shares one uart_tx instance between two byte-stream requesters (A = LiDAR

---
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx between two byte-stream requesters (A = LiDAR command
//   path, B = IMU config path). Ownership is held for a whole packet, ties are
//   broken round-robin, and a requester that stalls mid-packet is released
//   after TIMEOUT_CYCLES idle LOAD cycles (0 disables the release).
//
//   state | meaning
//   IDLE  | no owner; arbitrate between pending requesters
//   LOAD  | owner's ready high; waiting for its next byte
//   START | one-cycle start pulse to uart_tx with the latched byte
//   BUSY  | waiting for uart_tx done
//
// Ports
//   clk_in, rst_in                  clock, async active-high reset
//   a_valid_i/a_data_i/a_last_i     requester A byte stream, a_ready_o handshake
//   b_valid_i/b_data_i/b_last_i     requester B byte stream, b_ready_o handshake
//   tx_data_o, tx_start_o           to uart_tx data_i / start_i
//   tx_done_i                       from uart_tx done_o
//   grant_o                         one-hot owner {B,A}, 00 when idle
//   busy_o                          high outside IDLE
//   timeout_o                       one-cycle pulse on forced release
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       a_valid_i,
    input  logic [7:0] a_data_i,
    input  logic       a_last_i,
    output logic       a_ready_o,
    input  logic       b_valid_i,
    input  logic [7:0] b_data_i,
    input  logic       b_last_i,
    output logic       b_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_start_o,
    input  logic       tx_done_i,
    output logic [1:0] grant_o,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_served_q, last_served_d;  // 1 = B was served last
    logic [7:0]       tx_data_q, tx_data_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic             sel_valid;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic [CNT_W-1:0] cnt_inc;

    assign sel_valid = (grant_q[0] & a_valid_i) | (grant_q[1] & b_valid_i);
    assign sel_data  = grant_q[1] ? b_data_i : a_data_i;
    assign sel_last  = grant_q[1] ? b_last_i : a_last_i;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (a_valid_i && b_valid_i) begin
                    grant_d = last_served_q ? 2'b01 : 2'b10;
                    state_d = ST_LOAD;
                end else if (a_valid_i) begin
                    grant_d = 2'b01;
                    state_d = ST_LOAD;
                end else if (b_valid_i) begin
                    grant_d = 2'b10;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A byte arriving in the same cycle the idle count expires wins.
                if (sel_valid) begin
                    tx_data_d = sel_data;
                    last_d    = sel_last;
                    cnt_d     = '0;
                    state_d   = ST_START;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_MAX)) begin
                    timeout_d     = 1'b1;
                    last_served_d = grant_q[1];
                    grant_d       = 2'b00;
                    cnt_d         = '0;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_START: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (tx_done_i) begin
                    cnt_d = '0;
                    if (last_q) begin
                        last_served_d = grant_q[1];
                        grant_d       = 2'b00;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            grant_q       <= 2'b00;
            last_served_q <= 1'b1;
            tx_data_q     <= 8'h00;
            last_q        <= 1'b0;
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            tx_data_q     <= tx_data_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
        end
    end

    assign a_ready_o  = (state_q == ST_LOAD) & grant_q[0];
    assign b_ready_o  = (state_q == ST_LOAD) & grant_q[1];
    assign tx_data_o  = tx_data_q;
    assign tx_start_o = (state_q == ST_START);
    assign grant_o    = grant_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign timeout_o  = timeout_q;

endmodule
